// File: rtl/count_pkg.sv
// Shared types for the reload controller: FSM state encoding and a
// configuration record sized for the default counter width.
package count_pkg;

  localparam int DEF_WIDTH = 5;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ctrl_state_e;

  // One timer configuration: count reload..limit, optionally only once.
  typedef struct packed {
    logic [DEF_WIDTH-1:0] reload;
    logic [DEF_WIDTH-1:0] limit;
    logic                 oneshot;
  } cfg_t;

  // Configuration in force after reset: full-range free-running period.
  function automatic cfg_t cfg_default();
    cfg_t c;
    c.reload  = '0;
    c.limit   = '1;
    c.oneshot = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/cfg_shadow_reg.sv
// Two-stage configuration store: a one-entry pending slot filled through
// the valid/ready handshake, and the active set the timer runs from.
// Pending moves to active only when the controller pulses i_apply.
module cfg_shadow_reg
  import count_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             i_cfg_valid,
  input  logic [WIDTH-1:0] i_cfg_reload,
  input  logic [WIDTH-1:0] i_cfg_limit,
  input  logic             i_cfg_oneshot,
  input  logic             i_apply,
  output logic             o_cfg_ready,
  output logic             o_pend_valid,
  output logic [WIDTH-1:0] o_pend_reload,
  output logic [WIDTH-1:0] o_act_reload,
  output logic [WIDTH-1:0] o_act_limit,
  output logic             o_act_oneshot
);

  logic             r_pend_valid;
  logic [WIDTH-1:0] r_pend_reload;
  logic [WIDTH-1:0] r_pend_limit;
  logic             r_pend_oneshot;
  logic [WIDTH-1:0] r_act_reload;
  logic [WIDTH-1:0] r_act_limit;
  logic             r_act_oneshot;
  logic             w_accept;

  // Accept only into an empty slot, so accept and apply never collide.
  assign w_accept = i_cfg_valid && !r_pend_valid;

  // Pending/active registers: apply drains the slot, accept fills it.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      r_pend_valid   <= 1'b0;
      r_pend_reload  <= '0;
      r_pend_limit   <= '0;
      r_pend_oneshot <= 1'b0;
      r_act_reload   <= '0;
      r_act_limit    <= '1;
      r_act_oneshot  <= 1'b0;
    end else if (i_apply && r_pend_valid) begin
      r_act_reload  <= r_pend_reload;
      r_act_limit   <= r_pend_limit;
      r_act_oneshot <= r_pend_oneshot;
      r_pend_valid  <= 1'b0;
    end else if (w_accept) begin
      r_pend_reload  <= i_cfg_reload;
      r_pend_limit   <= i_cfg_limit;
      r_pend_oneshot <= i_cfg_oneshot;
      r_pend_valid   <= 1'b1;
    end
  end

  assign o_cfg_ready   = !r_pend_valid;
  assign o_pend_valid  = r_pend_valid;
  assign o_pend_reload = r_pend_reload;
  assign o_act_reload  = r_act_reload;
  assign o_act_limit   = r_act_limit;
  assign o_act_oneshot = r_act_oneshot;

endmodule

// File: rtl/count_reload_ctrl.sv
// Reload controller for an external WIDTH-bit loadable up-counter.
// Holds the counter at reload while idle; while running, reloads it when
// it reaches limit and emits a one-cycle tick per completed period.
//
// Config handshake: a transfer happens at a rising clk edge where
// cfg_valid && cfg_ready; cfg_reload/cfg_limit/cfg_oneshot are captured
// then. cfg_ready stays low while a captured config waits for the next
// period boundary (every cycle in IDLE, the hit cycle in RUN).
module count_reload_ctrl
  import count_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_reload,
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic             cfg_oneshot,
  input  logic [WIDTH-1:0] count,
  output logic             load,
  output logic [WIDTH-1:0] data,
  output logic             tick,
  output logic             running,
  output ctrl_state_e      dbg_state
);

  ctrl_state_e      r_state;
  ctrl_state_e      w_state_nxt;
  logic             r_tick;
  logic             w_hit;
  logic             w_apply;
  logic             w_pend_valid;
  logic [WIDTH-1:0] w_pend_reload;
  logic [WIDTH-1:0] w_act_reload;
  logic [WIDTH-1:0] w_act_limit;
  logic             w_act_oneshot;

  cfg_shadow_reg #(.WIDTH(WIDTH)) u_cfg (
    .clk           (clk),
    .rst_          (rst_),
    .i_cfg_valid   (cfg_valid),
    .i_cfg_reload  (cfg_reload),
    .i_cfg_limit   (cfg_limit),
    .i_cfg_oneshot (cfg_oneshot),
    .i_apply       (w_apply),
    .o_cfg_ready   (cfg_ready),
    .o_pend_valid  (w_pend_valid),
    .o_pend_reload (w_pend_reload),
    .o_act_reload  (w_act_reload),
    .o_act_limit   (w_act_limit),
    .o_act_oneshot (w_act_oneshot)
  );

  assign w_hit = (count == w_act_limit);

  // Next state, boundary (apply) pulse and counter load control.
  always_comb begin
    w_state_nxt = r_state;
    w_apply     = 1'b0;
    load        = 1'b1;
    case (r_state)
      IDLE: begin
        w_apply = 1'b1;
        load    = 1'b1;
        if (start && !stop) w_state_nxt = RUN;
      end
      RUN: begin
        w_apply = w_hit;
        load    = w_hit;
        if (stop) w_state_nxt = IDLE;
        else if (w_hit && w_act_oneshot) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    // Load the reload of whichever config governs the next period, so a
    // config applied at this boundary starts its own range immediately.
    data = (w_apply && w_pend_valid) ? w_pend_reload : w_act_reload;
  end

  // State register and tick, which fires in the cycle after each hit.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      r_state <= IDLE;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= (r_state == RUN) && w_hit;
    end
  end

  assign tick      = r_tick;
  assign running   = (r_state == RUN);
  assign dbg_state = r_state;

endmodule
